// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory-controller port.
// Each transfer is latched, issued, waited on with a timeout, and completed with a DONE pulse.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic [1:0]        CTRL0,
  input  logic [1:0]        CTRL1,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  output logic              GNT0,
  output logic              GNT1,
  output logic              DONE0,
  output logic              DONE1,
  output logic [47:0]       RDATA,
  output logic              ERR,
  output logic              MC_ENABLE,
  output logic [1:0]        MC_CTRL,
  output logic [ADDR_W-1:0] MC_ADDRESS,
  input  logic              MC_HANDSHAKE,
  input  logic [47:0]       MC_READ
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [1:0]          ctrl_q, ctrl_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                id_q, id_d;
  logic                last_q, last_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [47:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                winner;

  // On contention the requester not served last wins.
  always_comb begin
    if (REQ0 && REQ1) begin
      winner = ~last_q;
    end else begin
      winner = REQ1;
    end
  end

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    addr_d  = addr_q;
    id_d    = id_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (REQ0 || REQ1) begin
          id_d    = winner;
          ctrl_d  = winner ? CTRL1 : CTRL0;
          addr_d  = winner ? ADDR1 : ADDR0;
          cnt_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CntW'(1);
        end
        // Handshake takes priority over a coincident timeout.
        if (MC_HANDSHAKE) begin
          rdata_d = MC_READ;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q >= CntLast) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        last_d  = id_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
      addr_q  <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign GNT0       = (state_q == S_ISSUE) && !id_q;
  assign GNT1       = (state_q == S_ISSUE) && id_q;
  assign DONE0      = (state_q == S_DONE) && !id_q;
  assign DONE1      = (state_q == S_DONE) && id_q;
  assign MC_ENABLE  = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign MC_CTRL    = ctrl_q;
  assign MC_ADDRESS = addr_q;
  assign RDATA      = rdata_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized transfers
// checked against a transaction-level model of arbitration, timeout and results.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        CLK;
  logic        RESET;
  logic        REQ0, REQ1;
  logic [1:0]  CTRL0, CTRL1;
  logic [31:0] ADDR0, ADDR1;
  logic        GNT0, GNT1, DONE0, DONE1;
  logic [47:0] RDATA;
  logic        ERR;
  logic        MC_ENABLE;
  logic [1:0]  MC_CTRL;
  logic [31:0] MC_ADDRESS;
  logic        MC_HANDSHAKE;
  logic [47:0] MC_READ;

  int          n_vec = 0;
  int          n_err = 0;

  // Model state: last-served requester and held result.
  logic        m_last;
  logic [47:0] m_rd;
  logic        m_err;

  mem_port_arbiter #(
    .TIMEOUT(TO),
    .ADDR_W (32)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .REQ0        (REQ0),
    .REQ1        (REQ1),
    .CTRL0       (CTRL0),
    .CTRL1       (CTRL1),
    .ADDR0       (ADDR0),
    .ADDR1       (ADDR1),
    .GNT0        (GNT0),
    .GNT1        (GNT1),
    .DONE0       (DONE0),
    .DONE1       (DONE1),
    .RDATA       (RDATA),
    .ERR         (ERR),
    .MC_ENABLE   (MC_ENABLE),
    .MC_CTRL     (MC_CTRL),
    .MC_ADDRESS  (MC_ADDRESS),
    .MC_HANDSHAKE(MC_HANDSHAKE),
    .MC_READ     (MC_READ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] rnd48();
    return {16'($urandom), $urandom};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    RESET  = 1'b0;
    m_last = 1'b1;
    m_rd   = '0;
    m_err  = 1'b0;
  endtask

  // One full transfer, entered and left in an IDLE cycle.
  // hs: WAIT cycle index carrying the handshake, or out of range for none.
  task automatic xfer(input string tag, input logic r0, input logic r1,
                      input logic [1:0] c0, input logic [1:0] c1,
                      input logic [31:0] a0, input logic [31:0] a1,
                      input int hs, input logic [47:0] data);
    logic        w;
    logic [1:0]  ec;
    logic [31:0] ea;
    logic        hit;
    int          waits;
    int          en_cnt;
    logic        exp_err;
    logic [47:0] exp_rd;

    REQ0 = r0; REQ1 = r1; CTRL0 = c0; CTRL1 = c1; ADDR0 = a0; ADDR1 = a1;
    MC_HANDSHAKE = 1'b0;

    w       = (r0 && r1) ? (m_last == 1'b0) : r1;
    ec      = w ? c1 : c0;
    ea      = w ? a1 : a0;
    hit     = (hs >= 0) && (hs < TO);
    waits   = hit ? hs + 1 : TO;
    exp_err = !hit;
    exp_rd  = hit ? data : 48'h0;

    step();
    chk_b({tag, "_gnt0"}, GNT0, !w);
    chk_b({tag, "_gnt1"}, GNT1, w);
    chk_b({tag, "_issue_en"}, MC_ENABLE, 1'b1);
    chk_w({tag, "_issue_addr"}, 64'(MC_ADDRESS), 64'(ea));
    chk_w({tag, "_issue_ctrl"}, 64'(MC_CTRL), 64'(ec));
    en_cnt = int'(MC_ENABLE);

    // Post-grant changes must not disturb the latched transfer.
    ADDR0 = $urandom; ADDR1 = $urandom;
    CTRL0 = 2'($urandom); CTRL1 = 2'($urandom);
    MC_HANDSHAKE = 1'($urandom);
    MC_READ = rnd48();
    step();

    for (int i = 0; i < waits; i++) begin
      chk_b({tag, "_wait_en"}, MC_ENABLE, 1'b1);
      chk_w({tag, "_wait_addr"}, 64'(MC_ADDRESS), 64'(ea));
      chk_w({tag, "_wait_ctrl"}, 64'(MC_CTRL), 64'(ec));
      chk_b({tag, "_wait_nodone"}, DONE0 | DONE1 | GNT0 | GNT1, 1'b0);
      en_cnt += int'(MC_ENABLE);
      MC_HANDSHAKE = (i == hs);
      MC_READ      = (i == hs) ? data : rnd48();
      step();
    end

    MC_HANDSHAKE = 1'($urandom);
    MC_READ      = rnd48();
    chk_b({tag, "_done0"}, DONE0, !w);
    chk_b({tag, "_done1"}, DONE1, w);
    chk_b({tag, "_done_en"}, MC_ENABLE, 1'b0);
    chk_w({tag, "_rdata"}, 64'(RDATA), 64'(exp_rd));
    chk_b({tag, "_err"}, ERR, exp_err);
    chk_w({tag, "_en_cycles"}, 64'(en_cnt), 64'(1 + waits));
    m_last = w;
    m_rd   = exp_rd;
    m_err  = exp_err;
    step();

    MC_HANDSHAKE = 1'b0;
    chk_b({tag, "_idle_nodone"}, DONE0 | DONE1, 1'b0);
    chk_w({tag, "_rdata_hold"}, 64'(RDATA), 64'(m_rd));
    chk_b({tag, "_err_hold"}, ERR, m_err);
  endtask

  initial begin
    RESET = 1'b1;
    REQ0 = 1'b0; REQ1 = 1'b0; CTRL0 = '0; CTRL1 = '0; ADDR0 = '0; ADDR1 = '0;
    MC_HANDSHAKE = 1'b0; MC_READ = '0;
    m_last = 1'b1; m_rd = '0; m_err = 1'b0;

    step();
    chk_b("rst_gnt", GNT0 | GNT1, 1'b0);
    chk_b("rst_done", DONE0 | DONE1, 1'b0);
    chk_b("rst_en", MC_ENABLE, 1'b0);
    chk_w("rst_ctrl", 64'(MC_CTRL), 64'h0);
    chk_w("rst_addr", 64'(MC_ADDRESS), 64'h0);
    chk_w("rst_rdata", 64'(RDATA), 64'h0);
    chk_b("rst_err", ERR, 1'b0);
    RESET = 1'b0;
    step();

    // Minimum-latency single transfer.
    xfer("basic", 1'b1, 1'b0, 2'b01, 2'b00, 32'h100, 32'h0, 0, 48'h123456789ABC);

    // Both requesting continuously after reset: order 0,1,0.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      xfer("rr", 1'b1, 1'b1, 2'($urandom), 2'($urandom), $urandom, $urandom,
           int'($urandom_range(0, 2)), rnd48());
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    step();

    xfer("timeout", 1'b1, 1'b0, 2'b10, 2'b00, 32'hDEAD0000, 32'h0, -1, rnd48());
    xfer("hs_on_to", 1'b0, 1'b1, 2'b00, 2'b11, 32'h0, 32'hCAFE0040, TO - 1, 48'hA5A5_5A5A_0F0F);

    // Reset in the middle of WAIT.
    REQ0 = 1'b1; REQ1 = 1'b0; ADDR0 = $urandom;
    step();
    chk_b("midrst_gnt0", GNT0, 1'b1);
    REQ0 = 1'b0;
    step();
    chk_b("midrst_wait_en", MC_ENABLE, 1'b1);
    RESET = 1'b1;
    #1;
    chk_b("midrst_en_now", MC_ENABLE, 1'b0);
    chk_b("midrst_nodone_now", DONE0 | DONE1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk_b("midrst_nodone", DONE0 | DONE1, 1'b0);
    end
    RESET  = 1'b0;
    m_last = 1'b1; m_rd = '0; m_err = 1'b0;
    step();
    chk_b("midrst_nodone_after", DONE0 | DONE1, 1'b0);
    xfer("after_rst", 1'b0, 1'b1, 2'b00, 2'b01, 32'h0, 32'h0000_2000, 1, rnd48());

    for (int k = 0; k < 24; k++) begin
      logic [1:0] rq;
      rq = 2'($urandom_range(1, 3));
      xfer("rand", rq[0], rq[1], 2'($urandom), 2'($urandom), $urandom, $urandom,
           int'($urandom_range(0, TO + 2)) - 1, rnd48());
    end

    REQ0 = 1'b0; REQ1 = 1'b0;
    step();
    chk_b("final_idle_en", MC_ENABLE, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
